// File: rtl/bpsk_pkg.sv
// Shared elaboration helpers for the BPSK receive-path arithmetic blocks.
// Everything here is evaluated at elaboration time to size trees and pipelines.
package bpsk_pkg;

    function automatic int clog2_int(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tree_levels(input int n);
        return clog2_int(n);
    endfunction

    // Node count at the input of level k (level 0 sees the raw samples).
    function automatic int tree_nodes(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    function automatic int tree_latency(input int n, input int reg_every);
        int l;
        l = tree_levels(n);
        return (l == 0) ? 1 : (l + reg_every - 1) / reg_every;
    endfunction

    function automatic int out_width(input int n, input int width_in, input int acc_len);
        return width_in + clog2_int(n) + clog2_int(acc_len);
    endfunction

    // The last level is always registered so the accumulator sees a clean edge.
    function automatic bit stage_registered(input int k, input int levels, input int reg_every);
        return (((k + 1) % reg_every) == 0) || (k == levels - 1);
    endfunction

endpackage

// File: rtl/tree_adder_stage.sv
// One adder-tree level: pairwise adds with a one-bit-wider odd pass-through,
// optionally followed by a data/valid register.
module tree_adder_stage #(
    parameter int M      = 2,
    parameter int W      = 1,
    parameter bit SIGNED = 1'b0,
    parameter bit REG    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       valid_in,
    input  logic [M-1:0][W-1:0]        data_in,
    output logic                       valid_out,
    output logic [(M+1)/2-1:0][W:0]    data_out
);

    function automatic logic [W:0] ext(input logic [W-1:0] x);
        return SIGNED ? {x[W-1], x} : {1'b0, x};
    endfunction

    logic [(M+1)/2-1:0][W:0] node;

    for (genvar i = 0; i < (M + 1) / 2; i++) begin : g_node
        if (2 * i + 1 < M) begin : g_add
            assign node[i] = ext(data_in[2*i]) + ext(data_in[2*i+1]);
        end else begin : g_pass
            assign node[i] = ext(data_in[2*i]);
        end
    end

    if (REG) begin : g_reg
        logic                    valid_q;
        logic [(M+1)/2-1:0][W:0] data_q;

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        // NOTE: the data registers are reset even though valid alone qualifies
        // them, so the output bus reads zero after reset rather than stale X.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_in & ~clear;
                if (valid_in) data_q <= node;
            end
        end

        assign valid_out = valid_q;
        assign data_out  = data_q;
    end else begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, clear};
        assign valid_out   = valid_in;
        assign data_out    = node;
    end

endmodule

// File: rtl/pipelined_tree_adder.sv
// Streaming N-input adder tree with integrate-and-dump accumulation over
// ACC_LEN valid beats; result pulse arrives tree_latency()+1 cycles after a beat.
module pipelined_tree_adder
    import bpsk_pkg::*;
#(
    parameter int N         = 8,
    parameter int WIDTH_IN  = 1,
    parameter bit SIGNED    = 1'b0,
    parameter int REG_EVERY = 1,
    parameter int ACC_LEN   = 1,
    localparam int WIDTH_OUT = out_width(N, WIDTH_IN, ACC_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        valid_in,
    input  logic [N-1:0][WIDTH_IN-1:0]  data_in,
    output logic                        valid_out,
    output logic [WIDTH_OUT-1:0]        sum
);

    localparam int L  = tree_levels(N);
    localparam int WT = WIDTH_IN + L;
    localparam logic [WIDTH_OUT-1:0] LAST = WIDTH_OUT'(ACC_LEN - 1);

    logic [WT-1:0] tree_sum;
    logic          tree_valid;

    if (L == 0) begin : g_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tree_valid <= 1'b0;
                tree_sum   <= '0;
            end else begin
                tree_valid <= valid_in & ~clear;
                if (valid_in) tree_sum <= data_in[0];
            end
        end
    end else begin : g_tree
        for (genvar k = 0; k < L; k++) begin : lvl
            localparam int M_K = tree_nodes(N, k);
            localparam int W_K = WIDTH_IN + k;

            logic                          vin;
            logic [M_K-1:0][W_K-1:0]       din;
            logic                          vout;
            logic [(M_K+1)/2-1:0][W_K:0]   dout;

            if (k == 0) begin : g_first
                assign vin = valid_in;
                assign din = data_in;
            end else begin : g_chain
                assign vin = lvl[k-1].vout;
                assign din = lvl[k-1].dout;
            end

            tree_adder_stage #(
                .M      (M_K),
                .W      (W_K),
                .SIGNED (SIGNED),
                .REG    (stage_registered(k, L, REG_EVERY))
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .clear     (clear),
                .valid_in  (vin),
                .data_in   (din),
                .valid_out (vout),
                .data_out  (dout)
            );
        end

        assign tree_sum   = lvl[L-1].dout[0];
        assign tree_valid = lvl[L-1].vout;
    end

    logic [WIDTH_OUT-1:0] tree_ext;
    logic [WIDTH_OUT-1:0] acc_next;
    logic [WIDTH_OUT-1:0] acc;
    logic [WIDTH_OUT-1:0] cnt;

    if (SIGNED) begin : g_sext
        assign tree_ext = WIDTH_OUT'($signed(tree_sum));
    end else begin : g_zext
        assign tree_ext = WIDTH_OUT'(tree_sum);
    end

    // First beat of a block loads rather than adds, so acc never needs an explicit dump-clear.
    assign acc_next = (cnt == '0) ? tree_ext : acc + tree_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            sum       <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (clear) begin
                cnt <= '0;
                acc <= '0;
            end else if (tree_valid) begin
                if (cnt == LAST) begin
                    sum       <= acc_next;
                    valid_out <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + WIDTH_OUT'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Scoreboarded bench for pipelined_tree_adder across six parameter sets.
// Expected sums and due cycles are queued at drive time and matched on valid_out.
module tb_pipelined_tree_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instances: a N8/W4/U, b N5/W4/S, c N4/W4/U/ACC4, d N1/W8/S/RE2/ACC2,
    // e N9/W5/S/RE2/ACC3, f N16/W3/U/RE3
    localparam int CN  [6] = '{8, 5, 4, 1, 9, 16};
    localparam int CW  [6] = '{4, 4, 4, 8, 5, 3};
    localparam int CS  [6] = '{0, 1, 0, 1, 1, 0};
    localparam int CACC[6] = '{1, 1, 4, 2, 3, 1};
    localparam int CLAT[6] = '{4, 4, 3, 2, 3, 3};

    logic va, vb, vc, vd, ve, vf;
    logic [7:0][3:0]  din_a;
    logic [4:0][3:0]  din_b;
    logic [3:0][3:0]  din_c;
    logic [0:0][7:0]  din_d;
    logic [8:0][4:0]  din_e;
    logic [15:0][2:0] din_f;
    logic vo_a, vo_b, vo_c, vo_d, vo_e, vo_f;
    logic [6:0]  sum_a;
    logic [6:0]  sum_b;
    logic [7:0]  sum_c;
    logic [8:0]  sum_d;
    logic [10:0] sum_e;
    logic [6:0]  sum_f;

    pipelined_tree_adder #(.N(8), .WIDTH_IN(4), .SIGNED(1'b0), .REG_EVERY(1), .ACC_LEN(1)) u_a (
        .clk(clk), .rst(rst), .clear(clr), .valid_in(va), .data_in(din_a), .valid_out(vo_a), .sum(sum_a));
    pipelined_tree_adder #(.N(5), .WIDTH_IN(4), .SIGNED(1'b1), .REG_EVERY(1), .ACC_LEN(1)) u_b (
        .clk(clk), .rst(rst), .clear(clr), .valid_in(vb), .data_in(din_b), .valid_out(vo_b), .sum(sum_b));
    pipelined_tree_adder #(.N(4), .WIDTH_IN(4), .SIGNED(1'b0), .REG_EVERY(1), .ACC_LEN(4)) u_c (
        .clk(clk), .rst(rst), .clear(clr), .valid_in(vc), .data_in(din_c), .valid_out(vo_c), .sum(sum_c));
    pipelined_tree_adder #(.N(1), .WIDTH_IN(8), .SIGNED(1'b1), .REG_EVERY(2), .ACC_LEN(2)) u_d (
        .clk(clk), .rst(rst), .clear(clr), .valid_in(vd), .data_in(din_d), .valid_out(vo_d), .sum(sum_d));
    pipelined_tree_adder #(.N(9), .WIDTH_IN(5), .SIGNED(1'b1), .REG_EVERY(2), .ACC_LEN(3)) u_e (
        .clk(clk), .rst(rst), .clear(clr), .valid_in(ve), .data_in(din_e), .valid_out(vo_e), .sum(sum_e));
    pipelined_tree_adder #(.N(16), .WIDTH_IN(3), .SIGNED(1'b0), .REG_EVERY(3), .ACC_LEN(1)) u_f (
        .clk(clk), .rst(rst), .clear(clr), .valid_in(vf), .data_in(din_f), .valid_out(vo_f), .sum(sum_f));

    longint got [6];
    logic   vout[6];
    always_comb begin
        got[0] = longint'(sum_a);
        got[1] = longint'($signed(sum_b));
        got[2] = longint'(sum_c);
        got[3] = longint'($signed(sum_d));
        got[4] = longint'($signed(sum_e));
        got[5] = longint'(sum_f);
        vout[0] = vo_a; vout[1] = vo_b; vout[2] = vo_c;
        vout[3] = vo_d; vout[4] = vo_e; vout[5] = vo_f;
    end

    typedef struct {
        int     id;
        longint val;
        int     due;
    } exp_t;

    exp_t   sb[$];
    longint pacc[6];
    int     pcnt[6];
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            pacc[k] = 0;
            pcnt[k] = 0;
        end
    endtask

    task automatic model_beat(input int id, input int v[16]);
        exp_t e;
        longint s;
        s = 0;
        for (int i = 0; i < CN[id]; i++) s += longint'(v[i]);
        pacc[id] += s;
        pcnt[id]++;
        if (pcnt[id] == CACC[id]) begin
            e.id  = id;
            e.val = pacc[id];
            e.due = cyc + CLAT[id];
            sb.push_back(e);
            pacc[id] = 0;
            pcnt[id] = 0;
        end
    endtask

    task automatic set_beat(input int id, input int v[16]);
        case (id)
            0: begin for (int i = 0; i < 8;  i++) din_a[i] = v[i][3:0]; va = 1'b1; end
            1: begin for (int i = 0; i < 5;  i++) din_b[i] = v[i][3:0]; vb = 1'b1; end
            2: begin for (int i = 0; i < 4;  i++) din_c[i] = v[i][3:0]; vc = 1'b1; end
            3: begin din_d[0] = v[0][7:0]; vd = 1'b1; end
            4: begin for (int i = 0; i < 9;  i++) din_e[i] = v[i][4:0]; ve = 1'b1; end
            default: begin for (int i = 0; i < 16; i++) din_f[i] = v[i][2:0]; vf = 1'b1; end
        endcase
        if (!clr) model_beat(id, v);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        model_reset();
        for (int j = sb.size() - 1; j >= 0; j--)
            if (sb[j].due > cyc) sb.delete(j);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0; ve = 1'b0; vf = 1'b0;
        clr = 1'b0;
    endtask

    task automatic fill(output int v[16], input int x);
        for (int i = 0; i < 16; i++) v[i] = x;
    endtask

    task automatic rand_vals(input int id, output int v[16]);
        for (int i = 0; i < 16; i++) begin
            v[i] = int'($urandom_range(0, (1 << CW[id]) - 1));
            if (CS[id] != 0 && v[i] >= (1 << (CW[id] - 1))) v[i] -= (1 << CW[id]);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s_sum_%0d", tag, k), got[k], 0);
            check($sformatf("%s_vout_%0d", tag, k), longint'(vout[k]), 0);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int mon_idx;
    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (vout[k]) begin
                mon_idx = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (sb[j].id == k) begin
                        mon_idx = j;
                        break;
                    end
                check($sformatf("pulse_expected_%0d", k), longint'(mon_idx >= 0), 1);
                if (mon_idx >= 0) begin
                    check($sformatf("sum_%0d", k), got[k], sb[mon_idx].val);
                    check($sformatf("latency_%0d", k), longint'(cyc), longint'(sb[mon_idx].due));
                    sb.delete(mon_idx);
                end
            end
        end
    end

    initial begin
        int v[16];
        va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0; ve = 1'b0; vf = 1'b0;
        din_a = '0; din_b = '0; din_c = '0; din_d = '0; din_e = '0; din_f = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-scale unsigned beat: 8 x 15 = 120 after LAT=4.
        fill(v, 15); set_beat(0, v); tick();
        repeat (6) tick();

        // Signed N=5: most negative input everywhere, then a mixed vector back-to-back.
        fill(v, -8); set_beat(1, v); tick();
        v[0] = 7; v[1] = -1; v[2] = 3; v[3] = 0; v[4] = -2; set_beat(1, v); tick();
        repeat (6) tick();

        // ACC_LEN=4 with gaps between beats: one pulse with 16.
        fill(v, 1);
        set_beat(2, v); tick(); tick();
        set_beat(2, v); tick();
        set_beat(2, v); tick(); tick(); tick();
        set_beat(2, v); tick();
        repeat (5) tick();

        // Continuous stream: pulses every 4 cycles.
        repeat (8) begin set_beat(2, v); tick(); end
        repeat (5) tick();

        // Partial block flushed by clear, then a block of 2s gives 32.
        set_beat(2, v); tick();
        set_beat(2, v); tick();
        do_clear(); tick();
        fill(v, 2);
        repeat (4) begin set_beat(2, v); tick(); end
        repeat (5) tick();

        // Beat coinciding with clear is dropped.
        fill(v, 3); set_beat(2, v); do_clear(); tick();
        fill(v, 1);
        repeat (4) begin set_beat(2, v); tick(); end
        repeat (5) tick();

        // Clear in the cycle the final beat reaches the accumulator kills the result.
        repeat (4) begin set_beat(2, v); tick(); end
        tick();
        do_clear(); tick();
        repeat (4) tick();
        fill(v, 2);
        repeat (4) begin set_beat(2, v); tick(); end
        repeat (5) tick();

        // Asynchronous reset with a partial block and a beat in flight.
        fill(v, 1);
        set_beat(2, v); tick();
        set_beat(2, v); fill(v, 15); set_beat(0, v); tick();
        tick();
        reset_pulse();
        repeat (6) tick();
        fill(v, 1);
        repeat (4) begin set_beat(2, v); tick(); end
        rand_vals(0, v); set_beat(0, v); tick();
        repeat (6) tick();

        // Boundary vectors for the sweep configurations.
        fill(v, -128); set_beat(3, v);
        fill(v, -16);  set_beat(4, v);
        fill(v, 7);    set_beat(5, v);
        tick();
        fill(v, 127);  set_beat(3, v);
        fill(v, -16);  set_beat(4, v);
        tick();
        fill(v, -16);  set_beat(4, v);
        tick();

        // Random sweep with irregular gaps.
        repeat (80) begin
            for (int id = 3; id < 6; id++)
                if ($urandom_range(0, 3) != 0) begin
                    rand_vals(id, v);
                    set_beat(id, v);
                end
            tick();
        end
        repeat (10) tick();

        check("drain_pending", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
